// File: rtl/scan_seq_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_checker_if
//  Description : Bundles the scan-counter inputs, the error-clear request and
//                the checker status outputs into one interface. The master
//                side drives the counter; the slave side is the checker.
//  Revision    : 1.0  initial release
// ============================================================================
interface scan_seq_checker_if;

    logic [2:0] count_in;
    logic       loop_start_n;
    logic       err_clear;
    logic [7:0] sel;
    logic       locked;
    logic       frame_done;
    logic       seq_err;
    logic [7:0] loop_cnt;

    // Counter / host side
    modport master (
        output count_in,
        output loop_start_n,
        output err_clear,
        input  sel,
        input  locked,
        input  frame_done,
        input  seq_err,
        input  loop_cnt
    );

    // Checker side
    modport slave (
        input  count_in,
        input  loop_start_n,
        input  err_clear,
        output sel,
        output locked,
        output frame_done,
        output seq_err,
        output loop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/scan_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : scan_seq_checker
//  Description : Watches a free-running 3-bit scan counter and its active-low
//                loop marker. Locks on the first marked index 7, then expects
//                strictly incrementing (mod 8) steps. Produces a registered
//                one-hot select, a wrap pulse, a sticky error flag and a
//                saturating loop counter.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_seq_checker (
    input  wire                 clk,
    input  wire                 reset,
    scan_seq_checker_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_UNLOCKED = 1'b0;
    localparam logic [0:0] c_ST_LOCKED   = 1'b1;

    localparam logic [2:0] c_IDX_MARK    = 3'd7;
    localparam logic [2:0] c_IDX_FIRST   = 3'd0;
    localparam logic [7:0] c_CNT_MAX     = 8'hFF;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0] r_cnt_q;
    logic       r_ls_q;
    logic [0:0] r_state;
    logic [2:0] r_last_q;
    logic [7:0] r_sel;
    logic       r_locked;
    logic       r_frame_done;
    logic       r_seq_err;
    logic [7:0] r_loop_cnt;

    // ------------------------------------------------------------------------
    // Decision wires (built only from the registered inputs)
    // ------------------------------------------------------------------------
    logic       w_step;
    logic       w_is_mark_idx;
    logic       w_marker_err;
    logic [2:0] w_next_idx;
    logic       w_in_order;
    logic       w_lock_req;
    logic       w_seq_fault;
    logic       w_accept;
    logic       w_wrap;
    logic [7:0] w_sel_dec;

    // Decode an index into its one-hot select pattern
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] v;
        v      = 8'h00;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Combinational step / marker / ordering decisions
    always_comb begin
        w_is_mark_idx = (r_cnt_q == c_IDX_MARK);
        w_step        = (r_cnt_q != r_last_q);
        // Marker must be low exactly when the index is 7
        w_marker_err  = (r_ls_q == w_is_mark_idx);
        // 3-bit add wraps 7 -> 0 naturally
        w_next_idx    = r_last_q + 3'd1;
        w_in_order    = (r_cnt_q == w_next_idx);
        w_lock_req    = w_is_mark_idx && !r_ls_q;
        // Error checks outrank acceptance so a faulty wrap never pulses
        w_seq_fault   = w_marker_err || (w_step && !w_in_order);
        w_accept      = w_step && w_in_order && !w_marker_err;
        w_wrap        = w_accept && (r_last_q == c_IDX_MARK) && (r_cnt_q == c_IDX_FIRST);
        w_sel_dec     = onehot8(r_cnt_q);
    end

    // Input stage: capture the counter and marker every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= 3'd0;
            r_ls_q  <= 1'b1;
        end else begin
            r_cnt_q <= bus.count_in;
            r_ls_q  <= bus.loop_start_n;
        end
    end

    // Lock FSM with all status outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_UNLOCKED;
            r_last_q     <= 3'd0;
            r_sel        <= 8'h00;
            r_locked     <= 1'b0;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
            r_loop_cnt   <= 8'h00;
        end else begin
            // The wrap pulse lasts one cycle unless re-armed below
            r_frame_done <= 1'b0;
            // A clear request applies unless a new error lands on this edge
            if (bus.err_clear) begin
                r_seq_err <= 1'b0;
            end

            case (r_state)
                c_ST_UNLOCKED: begin
                    // Everything except a marked 7 is ignored while unlocked
                    if (w_lock_req) begin
                        r_state  <= c_ST_LOCKED;
                        r_last_q <= c_IDX_MARK;
                        r_sel    <= onehot8(c_IDX_MARK);
                        r_locked <= 1'b1;
                    end
                end

                c_ST_LOCKED: begin
                    if (w_seq_fault) begin
                        r_state   <= c_ST_UNLOCKED;
                        r_sel     <= 8'h00;
                        r_locked  <= 1'b0;
                        r_seq_err <= 1'b1;
                    end else if (w_accept) begin
                        r_last_q <= r_cnt_q;
                        r_sel    <= w_sel_dec;
                        if (w_wrap) begin
                            r_frame_done <= 1'b1;
                            if (r_loop_cnt != c_CNT_MAX) begin
                                r_loop_cnt <= r_loop_cnt + 8'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_state  <= c_ST_UNLOCKED;
                    r_sel    <= 8'h00;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.locked     = r_locked;
    assign bus.frame_done = r_frame_done;
    assign bus.seq_err    = r_seq_err;
    assign bus.loop_cnt   = r_loop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_seq_checker
//  Description : Directed vector table for scan_seq_checker plus a long
//                saturation run with a small reference of the wrap count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_seq_checker;

    typedef struct {
        logic       rst;
        logic [2:0] cnt;
        logic       ls_n;
        logic       clr;
        logic [7:0] sel;
        logic       lk;
        logic       fd;
        logic       err;
        logic [7:0] lc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    vec_t vecs[$];

    scan_seq_checker_if u_if ();

    scan_seq_checker u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one table row: inputs for this edge, outputs expected after it
    task automatic add(input logic r, input logic [2:0] c, input logic l, input logic e,
                       input logic [7:0] s, input logic k, input logic f,
                       input logic q, input logic [7:0] n);
        vec_t v;
        v.rst = r; v.cnt = c; v.ls_n = l; v.clr = e;
        v.sel = s; v.lk = k; v.fd = f; v.err = q; v.lc = n;
        vecs.push_back(v);
    endtask

    // Compare the full output set against the expected record
    task automatic check(input string name, input logic [7:0] s, input logic k,
                         input logic f, input logic q, input logic [7:0] n);
        n_vec++;
        if (u_if.sel !== s || u_if.locked !== k || u_if.frame_done !== f ||
            u_if.seq_err !== q || u_if.loop_cnt !== n) begin
            n_bad++;
            $display("FAIL %s: got sel=%h lk=%b fd=%b err=%b lc=%0d, want sel=%h lk=%b fd=%b err=%b lc=%0d",
                     name, u_if.sel, u_if.locked, u_if.frame_done, u_if.seq_err, u_if.loop_cnt,
                     s, k, f, q, n);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge
    task automatic drive(input logic r, input logic [2:0] c, input logic l, input logic e);
        reset           = r;
        u_if.count_in     = c;
        u_if.loop_start_n = l;
        u_if.err_clear    = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] v_prev;
        logic [2:0] v_now;
        logic [7:0] v_sel;
        logic [7:0] lc_exp;
        int         wraps;

        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        u_if.count_in     = 3'd0;
        u_if.loop_start_n = 1'b1;
        u_if.err_clear    = 1'b0;

        //   rst cnt ls clr   sel  lk fd er lc
        // Reset state
        add(1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        // Basic lock: 5,6,7,0,1 each held 3 cycles
        add(0, 5, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 5, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 5, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 6, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 6, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 6, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 7, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 7, 0, 0, 8'h80, 1, 0, 0, 0);
        add(0, 7, 0, 0, 8'h80, 1, 0, 0, 0);
        add(0, 0, 1, 0, 8'h80, 1, 0, 0, 0);
        add(0, 0, 1, 0, 8'h01, 1, 1, 0, 1);
        add(0, 0, 1, 0, 8'h01, 1, 0, 0, 1);
        add(0, 1, 1, 0, 8'h01, 1, 0, 0, 1);
        add(0, 1, 1, 0, 8'h02, 1, 0, 0, 1);
        add(0, 1, 1, 0, 8'h02, 1, 0, 0, 1);
        add(0, 2, 1, 0, 8'h02, 1, 0, 0, 1);
        add(0, 2, 1, 0, 8'h04, 1, 0, 0, 1);
        // Skip 2 -> 4
        add(0, 4, 1, 0, 8'h04, 1, 0, 0, 1);
        add(0, 4, 1, 0, 8'h00, 0, 0, 1, 1);
        add(0, 4, 1, 0, 8'h00, 0, 0, 1, 1);
        // Relock with clear on the locking edge
        add(0, 7, 0, 0, 8'h00, 0, 0, 1, 1);
        add(0, 7, 0, 1, 8'h80, 1, 0, 0, 1);
        add(0, 0, 1, 0, 8'h80, 1, 0, 0, 1);
        add(0, 1, 1, 0, 8'h01, 1, 1, 0, 2);
        add(0, 2, 1, 0, 8'h02, 1, 0, 0, 2);
        add(0, 3, 1, 0, 8'h04, 1, 0, 0, 2);
        // Marker fault: index 3 with marker low for one cycle
        add(0, 3, 0, 0, 8'h08, 1, 0, 0, 2);
        add(0, 3, 1, 0, 8'h00, 0, 0, 1, 2);
        // Unmarked 7 must not lock
        add(0, 7, 1, 1, 8'h00, 0, 0, 0, 2);
        add(0, 7, 1, 0, 8'h00, 0, 0, 0, 2);
        add(0, 7, 1, 0, 8'h00, 0, 0, 0, 2);
        // Clear versus error on the same edge
        add(0, 7, 0, 0, 8'h00, 0, 0, 0, 2);
        add(0, 0, 1, 0, 8'h80, 1, 0, 0, 2);
        add(0, 2, 1, 0, 8'h01, 1, 1, 0, 3);
        add(0, 2, 1, 1, 8'h00, 0, 0, 1, 3);
        add(0, 2, 1, 1, 8'h00, 0, 0, 0, 3);
        // Reset mid-loop at index 5
        add(0, 7, 0, 0, 8'h00, 0, 0, 0, 3);
        add(0, 0, 1, 0, 8'h80, 1, 0, 0, 3);
        add(0, 1, 1, 0, 8'h01, 1, 1, 0, 4);
        add(0, 2, 1, 0, 8'h02, 1, 0, 0, 4);
        add(0, 3, 1, 0, 8'h04, 1, 0, 0, 4);
        add(0, 4, 1, 0, 8'h08, 1, 0, 0, 4);
        add(0, 5, 1, 0, 8'h10, 1, 0, 0, 4);
        add(0, 5, 1, 0, 8'h20, 1, 0, 0, 4);
        add(1, 5, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 6, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 7, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 1, 0, 8'h80, 1, 0, 0, 0);
        add(0, 1, 1, 0, 8'h01, 1, 1, 0, 1);

        // Apply the table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].cnt, vecs[i].ls_n, vecs[i].clr);
            check($sformatf("row%0d", i), vecs[i].sel, vecs[i].lk, vecs[i].fd,
                  vecs[i].err, vecs[i].lc);
        end

        // Saturation: keep stepping one index per cycle for 260 more wraps
        v_prev = 3'd1;
        lc_exp = 8'd1;
        wraps  = 0;
        for (int i = 0; wraps < 260 && i < 4000; i++) begin
            v_now = v_prev + 3'd1;
            drive(1'b0, v_now, (v_now == 3'd7) ? 1'b0 : 1'b1, 1'b0);
            v_sel = 8'h00;
            v_sel[v_prev] = 1'b1;
            if (v_prev == 3'd0) begin
                wraps++;
                if (lc_exp != 8'hFF) lc_exp = lc_exp + 8'd1;
            end
            check($sformatf("sat%0d", i), v_sel, 1'b1, (v_prev == 3'd0), 1'b0, lc_exp);
            v_prev = v_now;
        end

        // Final saturated value, independent of the running model
        n_vec++;
        if (u_if.loop_cnt !== 8'd255 || wraps != 260) begin
            n_bad++;
            $display("FAIL sat_final: got lc=%0d wraps=%0d, want lc=255 wraps=260",
                     u_if.loop_cnt, wraps);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
